seu_emr_uart_reporter: RTL and testbench
========================================

// Module: seu_emr_uart_reporter
// PURPOSE
//  Downstream consumer of the SEU detector's external-processor EMR cache.
//  - Pops one EMR entry per request: waits for emr_cache_int, captures emr_data, pulses emr_cache_ack.
//  - Serialises the entry as a fixed-length byte frame on a valid/ready stream feeding the UART transmitter.
//  - Lets a host log SEU locations over the serial link.
// PARAMETERS
//  EMR_DATA_WIDTH  35  width of emr_data; must match the detector's emr_data_width
//  ACK_HOLDOFF     4   min cycles from an ack pulse until emr_cache_int is sampled again (cache pop latency)
//  SYNC_BYTE       8'hA5  first byte of every frame
// PORTS
//  clk              in   1   system clock
//  nreset           in   1   asynchronous active-low reset
//  enable           in   1   1 = accept new EMR entries; 0 = idle after the current frame
//  emr_data         in   EMR_DATA_WIDTH  head entry of the EMR cache
//  emr_cache_int    in   1   level; 1 while the cache holds >=1 entry
//  emr_cache_ack    out  1   one-cycle pulse; pops the head entry
//  cache_fill_level in   4   cache occupancy from the detector
//  cache_full       in   1   cache full from the detector
//  tx_data          out  8   frame byte to the UART TX
//  tx_valid         out  1   tx_data valid
//  tx_ready         in   1   UART TX accepts tx_data this cycle
//  busy             out  1   1 in any state other than IDLE
//  overflow_seen    out  1   sticky; set when cache_full=1 is sampled, cleared when reported
// BEHAVIOUR
//  Reset
//  - On nreset=0, asynchronously clear all outputs, seq, and the capture register to 0; state=IDLE.
//  - Reset mid-frame abandons the frame; no partial continuation.
//  Frame
//  - NB = ceil(EMR_DATA_WIDTH/8), which is 5 at the default width.
//  - FRAME_LEN = NB+4 bytes, in order: SYNC_BYTE, seq, flags, data bytes LSB-first (pad MSBs with 0), chk.
//  - flags = {ovf, 3'b000, cache_fill_level}, all sampled in the capture cycle.
//  - chk = XOR of every byte between SYNC_BYTE and chk (seq, flags, data).
//  - seq is an 8-bit counter, +1 after each completed frame; wraps 8'hFF -> 8'h00.
//  State machine (IDLE, CAPTURE, SEND, HOLD)
//  - IDLE: if enable & emr_cache_int & holdoff counter==0, go to CAPTURE.
//  - CAPTURE (1 cycle):
//    - Latch emr_data, cache_fill_level and overflow_seen; drive emr_cache_ack=1.
//    - Load the holdoff counter with ACK_HOLDOFF and clear overflow_seen.
//    - A cache_full=1 in this same cycle re-sets overflow_seen (set wins over clear).
//    - Go to SEND with byte index 0.
//  - SEND: tx_valid=1 and tx_data=byte[index].
//    - Advance the index only on tx_valid & tx_ready.
//    - tx_data stays stable while tx_ready=0.
//    - After byte FRAME_LEN-1 is accepted: seq++ and go to HOLD.
//  - HOLD: tx_valid=0; go to IDLE when the holdoff counter==0 (can be the same cycle as entry).
//  Holdoff counter and timing
//  - The counter decrements every cycle while nonzero, in every state.
//  - emr_cache_ack is high only in CAPTURE: exactly one cycle per frame, never back-to-back.
//  - Latency: emr_cache_int rising in IDLE -> ack on the next cycle -> first tx_valid the cycle after.
//  - Minimum frame period with tx_ready tied 1: 1+FRAME_LEN+1 cycles (11 at default).
//  Boundary conditions
//  - enable deasserted mid-frame: the frame completes; no new capture.
//  - emr_cache_int dropping during SEND/HOLD: ignored; only sampled in IDLE.
//  - cache_full sampled every cycle in every state.
//  - tx_ready while tx_valid=0: ignored.
// STRUCTURE
//  - Shared package (seu_pkg): state enum, SYNC_BYTE default, function frame_len(width).
//  - One natural sub-module, emr_frame_mux: combinational byte select over {chk, data, flags, seq, sync}, indexed by byte index.
//  - Top holds the FSM, capture register, seq, holdoff counter and the running XOR.
// TESTING
//  1. emr_data=35'h4_1234_5678, fill=3, tx_ready=1 -> bytes A5,00,03,78,56,34,12,04,0F; ack exactly 1 cycle.
//  2. Five entries queued (int held 1), tx_ready=1 -> five frames, seq 00..04, five ack pulses, each >= ACK_HOLDOFF apart.
//  3. tx_ready toggled 1,0,0,1 randomly -> tx_data stable while stalled; no byte lost or duplicated.
//  4. cache_full pulse before capture -> flags bit7=1 in that frame, 0 in the next; overflow_seen clears at capture.
//  5. nreset low during byte 4 -> tx_valid, ack, busy=0 at once; after release the next frame restarts at A5 with seq 00.
//  6. 256 frames -> seq wraps FF->00; enable=0 mid-frame -> frame finishes, then no ack while int=1.

Source files
------------

// File: rtl/seu_pkg.sv
// Shared types and frame-geometry helpers for the SEU EMR UART reporter.
package seu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Number of data bytes needed to carry an EMR entry of the given width.
    function automatic int unsigned num_data_bytes(input int unsigned width);
        return (width + 7) / 8;
    endfunction

    // Frame length: sync, seq, flags, data bytes, checksum.
    function automatic int unsigned frame_len(input int unsigned width);
        return num_data_bytes(width) + 4;
    endfunction

endpackage

// File: rtl/emr_frame_mux.sv
// Combinational byte selector for one report frame, indexed by byte position.
module emr_frame_mux
    import seu_pkg::*;
#(
    parameter int unsigned EMR_DATA_WIDTH = 35,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned IDX_W          = 4
) (
    input  logic [IDX_W-1:0]          idx,
    input  logic [7:0]                seq,
    input  logic [7:0]                flags,
    input  logic [EMR_DATA_WIDTH-1:0] data,
    input  logic [7:0]                chk,
    output logic [7:0]                frame_byte_c
);

    localparam int unsigned NB    = num_data_bytes(EMR_DATA_WIDTH);
    localparam int unsigned PAD_W = NB * 8;

    logic [PAD_W-1:0] data_pad;

    assign data_pad = PAD_W'(data);

    // Pick sync, seq, flags, LSB-first data bytes or checksum by position.
    always_comb begin
        frame_byte_c = 8'h00;
        if (idx == '0) begin
            frame_byte_c = SYNC_BYTE;
        end else if (idx == IDX_W'(1)) begin
            frame_byte_c = seq;
        end else if (idx == IDX_W'(2)) begin
            frame_byte_c = flags;
        end else if (idx == IDX_W'(NB + 3)) begin
            frame_byte_c = chk;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (idx == IDX_W'(i + 3)) begin
                    frame_byte_c = data_pad[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/seu_emr_uart_reporter.sv
// Pops EMR cache entries and streams each one as a checksummed byte frame.
module seu_emr_uart_reporter
    import seu_pkg::*;
#(
    parameter int unsigned EMR_DATA_WIDTH = 35,
    parameter int unsigned ACK_HOLDOFF    = 4,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      enable,
    input  logic [EMR_DATA_WIDTH-1:0] emr_data,
    input  logic                      emr_cache_int,
    output logic                      emr_cache_ack,
    input  logic [3:0]                cache_fill_level,
    input  logic                      cache_full,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      overflow_seen
);

    localparam int unsigned FRAME_LEN = frame_len(EMR_DATA_WIDTH);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned HOLD_W    = $clog2(ACK_HOLDOFF + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                seq;
    logic [7:0]                xor_acc;
    logic [EMR_DATA_WIDTH-1:0] cap_data;
    logic [3:0]                cap_fill;
    logic                      cap_ovf;
    logic [HOLD_W-1:0]         hold;

    logic [IDX_W-1:0]  next_idx_c;
    logic [7:0]        flags_c;
    logic [7:0]        next_byte_c;
    logic              accept_c;
    logic [HOLD_W-1:0] hold_dec_c;

    assign next_idx_c = idx + IDX_W'(1);
    assign flags_c    = {cap_ovf, 3'b000, cap_fill};
    assign accept_c   = tx_valid & tx_ready;
    assign hold_dec_c = (hold != '0) ? hold - HOLD_W'(1) : '0;

    // Byte for the position that becomes current after the next accept.
    emr_frame_mux #(
        .EMR_DATA_WIDTH (EMR_DATA_WIDTH),
        .SYNC_BYTE      (SYNC_BYTE),
        .IDX_W          (IDX_W)
    ) u_mux (
        .idx          (next_idx_c),
        .seq          (seq),
        .flags        (flags_c),
        .data         (cap_data),
        .chk          (xor_acc),
        .frame_byte_c (next_byte_c)
    );

    // Capture/send/holdoff sequencer with registered stream and handshake outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            seq           <= 8'h00;
            xor_acc       <= 8'h00;
            cap_data      <= '0;
            cap_fill      <= 4'h0;
            cap_ovf       <= 1'b0;
            hold          <= '0;
            emr_cache_ack <= 1'b0;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            overflow_seen <= 1'b0;
        end else begin
            hold          <= hold_dec_c;
            emr_cache_ack <= 1'b0;
            if (cache_full) begin
                overflow_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (enable && emr_cache_int && (hold == '0)) begin
                        state         <= ST_CAPTURE;
                        emr_cache_ack <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // Head entry is still valid here; the cache pops on this edge.
                    cap_data      <= emr_data;
                    cap_fill      <= cache_fill_level;
                    cap_ovf       <= overflow_seen;
                    overflow_seen <= cache_full;
                    hold          <= HOLD_W'(ACK_HOLDOFF);
                    idx           <= '0;
                    xor_acc       <= 8'h00;
                    tx_data       <= SYNC_BYTE;
                    tx_valid      <= 1'b1;
                    state         <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept_c) begin
                        if (idx == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            seq      <= seq + 8'd1;
                            if (hold_dec_c == '0) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end else begin
                            idx     <= next_idx_c;
                            tx_data <= next_byte_c;
                            // Checksum covers every byte between sync and chk.
                            if (next_idx_c != LAST_IDX) begin
                                xor_acc <= xor_acc ^ next_byte_c;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seu_emr_uart_reporter.sv
// Scoreboard bench for seu_emr_uart_reporter with a simple EMR cache model.
module tb_seu_emr_uart_reporter;

    localparam int unsigned W         = 35;
    localparam int unsigned HOLDOFF   = 4;
    localparam int unsigned FRAME_LEN = 9;

    logic          clk = 1'b0;
    logic          nreset;
    logic          enable;
    logic [W-1:0]  emr_data;
    logic          emr_cache_int;
    logic          emr_cache_ack;
    logic [3:0]    cache_fill_level;
    logic          cache_full;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          overflow_seen;

    int checks = 0;
    int errors = 0;

    // Cache model: entries written by the tests, popped by ack.
    logic [W-1:0] cache_mem [0:1023];
    logic [9:0]   wr_ptr = '0;
    logic [9:0]   rd_ptr = '0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_seq = 8'h00;

    int   cyc = 0;
    int   ack_count = 0;
    int   ack_cyc [0:1023];
    int   byte_count = 0;
    int   stall_count = 0;
    logic ack_prev = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    assign emr_cache_int = (wr_ptr != rd_ptr);
    assign emr_data      = cache_mem[rd_ptr];

    seu_emr_uart_reporter #(
        .EMR_DATA_WIDTH (W),
        .ACK_HOLDOFF    (HOLDOFF),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk              (clk),
        .nreset           (nreset),
        .enable           (enable),
        .emr_data         (emr_data),
        .emr_cache_int    (emr_cache_int),
        .emr_cache_ack    (emr_cache_ack),
        .cache_fill_level (cache_fill_level),
        .cache_full       (cache_full),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .overflow_seen    (overflow_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (emr_cache_ack) rd_ptr <= rd_ptr + 10'd1;
    end

    // Output monitor: scoreboard pops, stall stability, ack pulse shape.
    always @(negedge clk) begin
        if (!nreset) begin
            prev_stall = 1'b0;
            ack_prev   = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b data=%02h expected valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                byte_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h expected no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL frame_byte: got %02h expected %02h", tx_data, e);
                    end
                end
            end
            if (emr_cache_ack) begin
                checks++;
                if (ack_prev) begin
                    errors++;
                    $display("FAIL ack_width: got back-to-back ack expected single-cycle pulse");
                end
                ack_cyc[ack_count] = cyc;
                ack_count++;
            end
            if (tx_valid && !tx_ready) stall_count++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            ack_prev   = emr_cache_ack;
        end
    end

    task automatic cache_put(input logic [W-1:0] d);
        cache_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    // Reference frame builder: sync, seq, flags, data LSB-first, XOR checksum.
    task automatic expect_frame(input logic [W-1:0] d, input logic ovf, input logic [3:0] fill);
        logic [7:0]  b [0:8];
        logic [39:0] dp;
        logic [7:0]  x;
        dp   = {5'b0, d};
        b[0] = 8'hA5;
        b[1] = exp_seq;
        b[2] = {ovf, 3'b000, fill};
        for (int i = 0; i < 5; i++) b[3+i] = dp[i*8 +: 8];
        x = 8'h00;
        for (int i = 1; i < 8; i++) x = x ^ b[i];
        b[8] = x;
        for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (emr_cache_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; enable = 1'b0; tx_ready = 1'b0;
        cache_full = 1'b0; cache_fill_level = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        checks++;
        if (emr_cache_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", emr_cache_ack); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (overflow_seen !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_seen); end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b expected 0", busy); end
    endtask

    task automatic test_single_frame();
        logic [7:0] golden [0:8];
        int base;
        bit ok;
        golden = '{8'hA5, 8'h00, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h04, 8'h0F};
        cache_fill_level = 4'd3; tx_ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        base = ack_count;
        for (int i = 0; i < 9; i++) exp_q.push_back(golden[i]);
        exp_seq = exp_seq + 8'd1;
        cache_put(35'h4_1234_5678);
        @(negedge clk);
        checks++;
        if (emr_cache_ack !== 1'b1 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL latency_ack: got ack=%b valid=%b expected ack=1 valid=0", emr_cache_ack, tx_valid);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_capture: got %b expected 1", busy); end
        @(negedge clk);
        checks++;
        if (emr_cache_ack !== 1'b0 || tx_valid !== 1'b1) begin
            errors++; $display("FAIL latency_valid: got ack=%b valid=%b expected ack=0 valid=1", emr_cache_ack, tx_valid);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got busy expected idle within 100 cycles"); end
        checks++;
        if (ack_count - base != 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", ack_count - base); end
    endtask

    task automatic test_back_to_back();
        int base;
        int gap;
        bit ok;
        cache_fill_level = 4'd5; tx_ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        base = ack_count;
        for (int i = 0; i < 5; i++) begin
            logic [W-1:0] d;
            d = W'(64'h1_0000_0001) * W'(i + 1) ^ W'(35'h2_A5A5_5A5A);
            expect_frame(d, 1'b0, 4'd5);
            cache_put(d);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy expected idle within 200 cycles"); end
        checks++;
        if (ack_count - base != 5) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 5", ack_count - base); end
        for (int k = 1; k < 5; k++) begin
            gap = ack_cyc[base+k] - ack_cyc[base+k-1];
            checks++;
            if (gap < int'(HOLDOFF) || gap != int'(FRAME_LEN) + 2) begin
                errors++; $display("FAIL b2b_ack_gap: got %0d expected %0d", gap, FRAME_LEN + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int base_bytes;
        int base_stalls;
        bit done;
        cache_fill_level = 4'd2; enable = 1'b1;
        @(negedge clk);
        base_bytes  = byte_count;
        base_stalls = stall_count;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] d;
            d = W'($urandom());
            d[W-1:32] = 3'(i + 5);
            expect_frame(d, 1'b0, 4'd2);
            cache_put(d);
        end
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            tx_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && !busy && !tx_valid) begin
                done = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        checks++;
        if (!done) begin errors++; $display("FAIL bp_timeout: got busy expected idle within 600 cycles"); end
        checks++;
        if (byte_count - base_bytes != 27) begin
            errors++; $display("FAIL bp_byte_count: got %0d expected 27", byte_count - base_bytes);
        end
        checks++;
        if (stall_count == base_stalls) begin
            errors++; $display("FAIL bp_stalls: got 0 stalled cycles expected at least 1");
        end
    endtask

    task automatic test_overflow();
        bit ok;
        cache_fill_level = 4'd7; tx_ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        cache_full = 1'b1;
        @(negedge clk);
        cache_full = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow_seen !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_seen); end
        expect_frame(35'h7_0F0F_F0F0, 1'b1, 4'd7);
        expect_frame(35'h0_1357_9BDF, 1'b0, 4'd7);
        cache_put(35'h7_0F0F_F0F0);
        cache_put(35'h0_1357_9BDF);
        wait_ack(20, ok);
        checks++;
        if (!ok || overflow_seen !== 1'b1) begin
            errors++; $display("FAIL ovf_at_ack: got ack_seen=%b ovf=%b expected 1 1", ok, overflow_seen);
        end
        @(negedge clk);
        checks++;
        if (overflow_seen !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow_seen); end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_timeout: got busy expected idle within 100 cycles"); end
    endtask

    task automatic test_reset_midframe();
        int base;
        bit ok;
        cache_fill_level = 4'd1; tx_ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        base = byte_count;
        expect_frame(35'h5_5555_AAAA, 1'b0, 4'd1);
        cache_put(35'h5_5555_AAAA);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (byte_count - base >= 4) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (!ok || tx_valid !== 1'b0 || emr_cache_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midframe_reset: got reached=%b valid=%b ack=%b busy=%b expected 1 0 0 0",
                               ok, tx_valid, emr_cache_ack, busy);
        end
        exp_q.delete();
        exp_seq = 8'h00;
        wr_ptr  = rd_ptr;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        expect_frame(35'h1_2345_6789, 1'b0, 4'd1);
        cache_put(35'h1_2345_6789);
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL restart_timeout: got busy expected idle within 100 cycles"); end
    endtask

    task automatic test_seq_wrap_and_enable();
        int base;
        bit ok;
        cache_fill_level = 4'd0; tx_ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        base = ack_count;
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] d;
            d = W'(i * 32'h0101_0101);
            expect_frame(d, 1'b0, 4'd0);
            cache_put(d);
        end
        wait_idle(3500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: got busy expected idle within 3500 cycles"); end
        checks++;
        if (ack_count - base != 256) begin errors++; $display("FAIL wrap_ack_count: got %0d expected 256", ack_count - base); end
        // enable dropped mid-frame: only the in-flight frame completes
        base = ack_count;
        expect_frame(35'h3_DEAD_BEEF, 1'b0, 4'd0);
        cache_put(35'h3_DEAD_BEEF);
        cache_put(35'h6_CAFE_F00D);
        wait_ack(20, ok);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL disable_timeout: got busy expected idle within 100 cycles"); end
        repeat (30) @(negedge clk);
        checks++;
        if (ack_count - base != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL disable_no_capture: got acks=%0d busy=%b expected 1 0", ack_count - base, busy);
        end
        expect_frame(35'h6_CAFE_F00D, 1'b0, 4'd0);
        enable = 1'b1;
        wait_idle(100, ok);
        checks++;
        if (!ok || ack_count - base != 2) begin
            errors++; $display("FAIL reenable: got done=%b acks=%0d expected 1 2", ok, ack_count - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midframe();
        test_seq_wrap_and_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
